// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit.
// Holds the access-size encodings, the FSM state type, the WB bit positions
// and the default datapath / data-memory address widths, plus a small helper
// that decides whether an access is misaligned for its size.
package mem_access_unit_pkg;

    localparam int INTERNAL_BITS      = 32;
    localparam int DATA_MEM_ADDR_BITS = 13;

    // Access size encodings carried in mem_size
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Bit positions inside the 2-bit WB field {RegWrite, MemToReg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEM2REG  = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Half needs addr[0]=0; word (and the spare 11 code) needs addr[1:0]=00.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] lo);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = lo[0];
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data aligner.
// Picks the byte or half-word addressed by lo out of the memory word and
// sign- or zero-extends it to the datapath width. Words pass through.
// Ports:
//   rdata  in  DATA_W  raw word read from data memory
//   lo     in  2       byte offset (address bits [1:0])
//   size   in  2       access size (SIZE_B/H/W, 11 treated as word)
//   uns    in  1       zero-extend instead of sign-extend
//   result out DATA_W  aligned and extended load value
module mem_access_unit_load_align
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = INTERNAL_BITS
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        lo,
    input  logic [1:0]        size,
    input  logic              uns,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    always_comb begin
        sel_b = rdata[7:0];
        case (lo)
            2'd0:    sel_b = rdata[7:0];
            2'd1:    sel_b = rdata[15:8];
            2'd2:    sel_b = rdata[23:16];
            default: sel_b = rdata[31:24];
        endcase
        sel_h = lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result = rdata;
        case (size)
            SIZE_B: result = uns ? {{(DATA_W-8){1'b0}}, sel_b}
                                 : {{(DATA_W-8){sel_b[7]}}, sel_b};
            SIZE_H: result = uns ? {{(DATA_W-16){1'b0}}, sel_h}
                                 : {{(DATA_W-16){sel_h[15]}}, sel_h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller of the 5-stage pipeline.
// Takes a load/store from EX/MEM, runs one request/acknowledge transaction
// with data memory, formats store data/byte-enables, aligns load data and
// drives the MEM/WB register inputs. The front of the pipe is stalled while
// a transaction is in flight.
//
// Handshake: dm_req rises on the edge that leaves IDLE and stays high until
// the first cycle dm_ack is sampled high; that edge completes the transfer.
// dm_we/dm_addr/dm_wdata/dm_be are stable for the whole time dm_req is high.
// dm_ack outside ACCESS is ignored.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   ex_valid, mem_read, mem_write, mem_size, mem_unsigned,
//   alu_result, store_data, wb_in      EX/MEM register outputs
//   dm_req, dm_we, dm_addr, dm_wdata, dm_be  registered memory request
//   dm_rdata, dm_ack         memory response
//   stall                    freezes PC/IF/ID/EX and EX/MEM
//   wb_out, wb_addr, wb_rdata, wb_valid  MEM/WB register inputs
//   misalign, bus_err        one-cycle error pulses
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W   = INTERNAL_BITS,
    parameter int ADDR_W   = DATA_MEM_ADDR_BITS,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [1:0]        wb_in,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-3:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic [3:0]        dm_be,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack,
    output logic              stall,
    output logic [1:0]        wb_out,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_rdata,
    output logic              wb_valid,
    output logic              misalign,
    output logic              bus_err
);

    localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t state, state_next;

    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        wb_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [WAIT_W-1:0] wait_cnt;

    logic              mem_op;
    logic              mis;
    logic              launch;
    logic              timeout;
    logic [3:0]        be_fmt;
    logic [DATA_W-1:0] wdata_fmt;
    logic [DATA_W-1:0] load_val;

    // Address bits above the data-memory range are not part of the access.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, alu_result[DATA_W-1:ADDR_W]};

    assign mem_op = ex_valid & (mem_read | mem_write);
    assign mis    = is_misaligned(mem_size, alu_result[1:0]);

    assign dm_req   = req_q;
    assign dm_we    = we_q;
    assign dm_addr  = addr_q[ADDR_W-1:2];
    assign dm_wdata = wdata_q;
    assign dm_be    = be_q;

    // Store lanes are replicated so memory only has to honour byte enables.
    always_comb begin
        case (mem_size)
            SIZE_B: begin
                wdata_fmt = {4{store_data[7:0]}};
                be_fmt    = 4'b0001 << alu_result[1:0];
            end
            SIZE_H: begin
                wdata_fmt = {2{store_data[15:0]}};
                be_fmt    = alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_fmt = store_data;
                be_fmt    = 4'b1111;
            end
        endcase
        if (!mem_write) begin
            be_fmt = 4'b1111;
        end
    end

    mem_access_unit_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .rdata  (dm_rdata),
        .lo     (addr_q[1:0]),
        .size   (size_q),
        .uns    (uns_q),
        .result (load_val)
    );

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        wb_out     = wb_in;
        wb_addr    = alu_result[ADDR_W-1:0];
        wb_rdata   = '0;
        wb_valid   = ex_valid;
        misalign   = 1'b0;
        bus_err    = 1'b0;
        launch     = 1'b0;
        timeout    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_op) begin
                    // Memory ops never pass straight through; they either
                    // bubble (misaligned) or wait for DONE.
                    wb_out   = 2'b00;
                    wb_valid = 1'b0;
                    if (mis) begin
                        misalign = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        launch     = 1'b1;
                        state_next = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                stall    = 1'b1;
                wb_out   = 2'b00;
                wb_valid = 1'b0;
                if (dm_ack) begin
                    state_next = ST_DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    bus_err    = 1'b1;
                    timeout    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                wb_out     = wb_q;
                wb_addr    = addr_q;
                wb_rdata   = rdata_q;
                wb_valid   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wb_q     <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (launch) begin
                req_q    <= 1'b1;
                we_q     <= mem_write;
                addr_q   <= alu_result[ADDR_W-1:0];
                wb_q     <= wb_in;
                size_q   <= mem_size;
                uns_q    <= mem_unsigned;
                be_q     <= be_fmt;
                wdata_q  <= wdata_fmt;
                wait_cnt <= '0;
            end
            if (state == ST_ACCESS) begin
                if (dm_ack) begin
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    rdata_q <= we_q ? '0 : load_val;
                end else if (timeout) begin
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    rdata_q <= '0;
                    wb_q    <= 2'b00;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: reset values, pass-through, loads and
// stores of every size with several wait counts, misalignment, timeout and
// reset in the middle of a transaction.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic        mem_unsigned = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic [1:0]  wb_in = 2'b00;
    logic        dm_req;
    logic        dm_we;
    logic [10:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata = '0;
    logic        dm_ack = 1'b0;
    logic        stall;
    logic [1:0]  wb_out;
    logic [12:0] wb_addr;
    logic [31:0] wb_rdata;
    logic        wb_valid;
    logic        misalign;
    logic        bus_err;

    int vectors = 0;
    int miscompares = 0;

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .wb_in        (wb_in),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_be        (dm_be),
        .dm_rdata     (dm_rdata),
        .dm_ack       (dm_ack),
        .stall        (stall),
        .wb_out       (wb_out),
        .wb_addr      (wb_addr),
        .wb_rdata     (wb_rdata),
        .wb_valid     (wb_valid),
        .misalign     (misalign),
        .bus_err      (bus_err)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Runs one aligned load/store from IDLE through DONE and back to IDLE.
    // Called at posedge+1 with the unit idle; ack arrives after 'waits'
    // ACCESS cycles without it.
    task automatic run_op(input string name, input logic we,
                          input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] rdata, input logic [1:0] wb,
                          input int waits, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata,
                          input logic [31:0] exp_res);
        int n_stall;
        ex_valid     = 1'b1;
        mem_read     = ~we;
        mem_write    = we;
        mem_size     = size;
        mem_unsigned = uns;
        alu_result   = addr;
        store_data   = sd;
        wb_in        = wb;
        dm_ack       = 1'b0;
        #1;
        chk({name, ".idle_stall"}, 32'(stall), 32'd1);
        chk({name, ".idle_req"}, 32'(dm_req), 32'd0);
        n_stall = int'(stall);
        for (int i = 0; i <= waits; i++) begin
            @(posedge clk); #1;
            dm_ack   = (i == waits);
            dm_rdata = rdata;
            #1;
            n_stall += int'(stall);
            chk({name, ".req"}, 32'(dm_req), 32'd1);
            if (i == 0) begin
                chk({name, ".we"}, 32'(dm_we), 32'(we));
                chk({name, ".be"}, 32'(dm_be), 32'(exp_be));
                chk({name, ".wdata"}, dm_wdata, exp_wdata);
                chk({name, ".addr"}, 32'(dm_addr), 32'(addr[12:2]));
            end
        end
        @(posedge clk); #1;
        dm_ack    = 1'b0;
        ex_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        #1;
        chk({name, ".done_stall"}, 32'(stall), 32'd0);
        chk({name, ".done_req"}, 32'(dm_req), 32'd0);
        chk({name, ".wb_valid"}, 32'(wb_valid), 32'd1);
        chk({name, ".wb_out"}, 32'(wb_out), 32'(wb));
        chk({name, ".wb_addr"}, 32'(wb_addr), 32'(addr[12:0]));
        chk({name, ".wb_rdata"}, wb_rdata, exp_res);
        chk({name, ".stall_cycles"}, 32'(n_stall), 32'(waits + 2));
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req", 32'(dm_req), 32'd0);
        chk("rst.we", 32'(dm_we), 32'd0);
        chk("rst.be", 32'(dm_be), 32'd0);
        chk("rst.addr", 32'(dm_addr), 32'd0);
        chk("rst.wdata", dm_wdata, 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Non-memory op passes straight through
        ex_valid   = 1'b1;
        wb_in      = 2'b10;
        alu_result = 32'h0000_1234;
        #1;
        chk("pass.wb_out", 32'(wb_out), 32'h2);
        chk("pass.wb_addr", 32'(wb_addr), 32'h1234);
        chk("pass.stall", 32'(stall), 32'd0);
        chk("pass.wb_valid", 32'(wb_valid), 32'd1);
        chk("pass.wb_rdata", wb_rdata, 32'd0);
        chk("pass.req", 32'(dm_req), 32'd0);
        @(posedge clk); #1;
        alu_result = 32'hFFFF_E001;
        #1;
        chk("pass2.wb_addr", 32'(wb_addr), 32'h0001);
        chk("pass2.req", 32'(dm_req), 32'd0);
        ex_valid = 1'b0;
        #1;
        chk("pass3.wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clk); #1;

        // Loads and stores
        run_op("lb_s", 1'b0, 2'b00, 1'b0, 32'h003, 32'h0, 32'h80FF_FF7F,
               2'b11, 0, 4'hF, 32'h0, 32'hFFFF_FF80);
        run_op("lbu", 1'b0, 2'b00, 1'b1, 32'h001, 32'h0, 32'h80FF_FF7F,
               2'b11, 1, 4'hF, 32'h0, 32'h0000_00FF);
        run_op("lh_s", 1'b0, 2'b01, 1'b0, 32'h00A, 32'h0, 32'h80FF_1234,
               2'b11, 0, 4'hF, 32'h0, 32'hFFFF_80FF);
        run_op("lhu", 1'b0, 2'b01, 1'b1, 32'h008, 32'h0, 32'h1234_F00D,
               2'b11, 2, 4'hF, 32'h0, 32'h0000_F00D);
        run_op("lw", 1'b0, 2'b10, 1'b0, 32'h1FFC, 32'h0, 32'hDEAD_BEEF,
               2'b11, 1, 4'hF, 32'h0, 32'hDEAD_BEEF);
        run_op("lw11", 1'b0, 2'b11, 1'b0, 32'h004, 32'h0, 32'h0123_4567,
               2'b11, 0, 4'hF, 32'h0, 32'h0123_4567);
        run_op("sh", 1'b1, 2'b01, 1'b0, 32'h002, 32'h0000_ABCD, 32'hFFFF_FFFF,
               2'b01, 3, 4'hC, 32'hABCD_ABCD, 32'h0);
        run_op("sb", 1'b1, 2'b00, 1'b0, 32'h105, 32'h1234_5678, 32'h0,
               2'b00, 0, 4'h2, 32'h7878_7878, 32'h0);
        run_op("sw", 1'b1, 2'b10, 1'b0, 32'h040, 32'hCAFE_F00D, 32'h0,
               2'b00, 1, 4'hF, 32'hCAFE_F00D, 32'h0);

        // Misaligned word load
        ex_valid   = 1'b1;
        mem_read   = 1'b1;
        mem_size   = 2'b10;
        alu_result = 32'h006;
        wb_in      = 2'b11;
        #1;
        chk("mis_w.misalign", 32'(misalign), 32'd1);
        chk("mis_w.wb_out", 32'(wb_out), 32'd0);
        chk("mis_w.stall", 32'(stall), 32'd0);
        chk("mis_w.wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clk); #1;
        chk("mis_w.req", 32'(dm_req), 32'd0);
        mem_size   = 2'b01;
        alu_result = 32'h001;
        #1;
        chk("mis_h.misalign", 32'(misalign), 32'd1);
        ex_valid = 1'b0;
        mem_read = 1'b0;
        #1;
        chk("mis_end.misalign", 32'(misalign), 32'd0);
        @(posedge clk); #1;
        chk("mis_end.req", 32'(dm_req), 32'd0);

        // Timeout: ack never arrives
        ex_valid   = 1'b1;
        mem_read   = 1'b1;
        mem_size   = 2'b10;
        alu_result = 32'h010;
        wb_in      = 2'b11;
        dm_ack     = 1'b0;
        dm_rdata   = 32'h5555_5555;
        #1;
        chk("to.idle_stall", 32'(stall), 32'd1);
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk); #1;
            chk("to.req", 32'(dm_req), 32'd1);
            chk("to.bus_err", 32'(bus_err), 32'(i == 15));
        end
        @(posedge clk); #1;
        ex_valid = 1'b0;
        mem_read = 1'b0;
        #1;
        chk("to.done_bus_err", 32'(bus_err), 32'd0);
        chk("to.done_req", 32'(dm_req), 32'd0);
        chk("to.wb_out", 32'(wb_out), 32'd0);
        chk("to.wb_rdata", wb_rdata, 32'd0);
        chk("to.wb_valid", 32'(wb_valid), 32'd1);
        @(posedge clk); #1;

        // Reset in the middle of ACCESS, then a stray ack
        ex_valid   = 1'b1;
        mem_read   = 1'b1;
        mem_size   = 2'b10;
        alu_result = 32'h020;
        wb_in      = 2'b11;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        mem_read = 1'b0;
        #1;
        chk("mrst.req_before", 32'(dm_req), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst    = 1'b1;
        dm_ack = 1'b1;
        #1;
        chk("mrst.req", 32'(dm_req), 32'd0);
        chk("mrst.stall", 32'(stall), 32'd0);
        chk("mrst.be", 32'(dm_be), 32'd0);
        @(posedge clk); #1;
        dm_ack = 1'b0;
        #1;
        chk("mrst.ack_ignored_req", 32'(dm_req), 32'd0);
        chk("mrst.ack_ignored_valid", 32'(wb_valid), 32'd0);
        chk("mrst.ack_ignored_stall", 32'(stall), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage controller of the 5-stage pipeline.
- Takes the memory operation from the EX/MEM register and runs the request/acknowledge transaction to data memory.
- Formats store data and byte-enables; aligns and extends load data.
- Drives the inputs of the MEM/WB pipeline register (WB bits, address, read data) and stalls the front of the pipe while a transaction is outstanding.

Parameters:
- DATA_W, 32, datapath width (matches `INTERNAL_BITS`).
- ADDR_W, 13, byte address width (matches `DATA_MEM_ADDR_BITS`).
- MAX_WAIT, 15, ACCESS cycles without ack before timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- ex_valid  in  1  EX/MEM holds a valid instruction.
- mem_read  in  1  load.
- mem_write  in  1  store; wins if both are set.
- mem_size  in  2  00 byte, 01 half, 10 word (11 treated as word).
- mem_unsigned  in  1  zero-extend loads.
- alu_result  in  DATA_W  effective address / ALU value.
- store_data  in  DATA_W  rs2 value.
- wb_in  in  2  {RegWrite, MemToReg}.
- dm_req  out  1  memory request, registered.
- dm_we  out  1  write strobe, registered.
- dm_addr  out  ADDR_W-2  word address, registered.
- dm_wdata  out  DATA_W  replicated store data, registered.
- dm_be  out  4  byte enables, registered.
- dm_rdata  in  DATA_W  memory read word.
- dm_ack  in  1  transaction complete.
- stall  out  1  freeze PC/IF/ID/EX and EX/MEM.
- wb_out  out  2  to MEM/WB WB_in.
- wb_addr  out  ADDR_W  to MEM/WB Address_in.
- wb_rdata  out  DATA_W  to MEM/WB Read_data_in.
- wb_valid  out  1  result valid this cycle.
- misalign  out  1  one-cycle pulse.
- bus_err  out  1  one-cycle pulse, timeout.

Behaviour:
- FSM states: IDLE, ACCESS, DONE.
- Reset (rst=0 at a clk edge):
  - state goes to IDLE; wait counter, request registers and rdata_q all go to 0.
  - dm_req, dm_we, dm_be, dm_addr and dm_wdata read 0.
  - Outputs settle to the IDLE pass-through values.
  - A reset mid-ACCESS abandons the transaction; a later dm_ack in IDLE is ignored.
- IDLE, no memory op (ex_valid=0 or neither read nor write):
  - stall=0, wb_out=wb_in, wb_addr=alu_result[ADDR_W-1:0], wb_rdata=0, wb_valid=ex_valid.
  - This path is combinational.
- IDLE, memory op, misaligned (half with addr[0]=1; word with addr[1:0]≠0):
  - no request is issued.
  - misalign=1, wb_out=00 (bubble), stall=0, wb_valid=0.
- IDLE, memory op, aligned:
  - stall=1.
  - Latch into registers: addr, wb_in, size, unsigned, we, byte-enables and formatted wdata.
  - Next state ACCESS; wait counter cleared.
- Store formatting:
  - byte: wdata={4{sd[7:0]}}, be=0001<<addr[1:0].
  - half: wdata={2{sd[15:0]}}, be=addr[1]?1100:0011.
  - word: wdata=sd, be=1111.
  - For loads, be=1111 and we=0.
- ACCESS:
  - dm_req=1, stall=1.
  - dm_ack=1: capture the formatted load into rdata_q (stores capture 0); next state DONE.
  - Otherwise the counter increments. When the counter reaches MAX_WAIT: bus_err=1, rdata_q=0, WB forced to 00, next state DONE.
- DONE:
  - dm_req=0, stall=0.
  - wb_out=latched WB, wb_addr=latched addr, wb_rdata=rdata_q, wb_valid=1.
  - Inputs are ignored this cycle; next state IDLE.
  - Upstream advances at this edge, so the same instruction is never reissued.
- Load formatting:
  - select the byte/half at addr[1:0].
  - Sign-extend unless mem_unsigned is set.
- Latency: minimum 3 cycles in-stage (IDLE → ACCESS with immediate ack → DONE). Each extra wait cycle adds 1.

Decomposition:
- Shared `def.v` holds:
  - size encodings (SIZE_B/H/W).
  - FSM state codes.
  - WB bit positions (WB_REGWRITE=1, WB_MEM2REG=0).
  - `INTERNAL_BITS` and `DATA_MEM_ADDR_BITS` as parameter defaults.
- One sub-module, load_align: combinational, (rdata, addr[1:0], size, unsigned) → extended DATA_W result.

Test Plan:
- Non-memory op: ex_valid=1, wb_in=10, alu_result=0x1234 → same-cycle wb_out=10, wb_addr=0x1234 truncated to 13 bits, stall=0, dm_req never asserted.
- Signed byte load: addr=0x003, dm_rdata=0x80FF_FF7F, ack on first ACCESS cycle → stall high for 2 cycles; DONE shows wb_rdata=0xFFFFFF80, wb_valid=1.
- Half store: addr=0x002, store_data=0x0000ABCD → dm_we=1, dm_be=1100, dm_wdata=0xABCDABCD, dm_addr=0x000; ack after 3 wait cycles → stall spans 5 cycles.
- Misaligned word load: addr=0x006 → misalign=1 for 1 cycle, wb_out=00, no dm_req.
- Timeout: load with dm_ack held 0 → bus_err after 15 ACCESS cycles; DONE shows wb_out=00, wb_rdata=0.
- Reset mid-ACCESS: rst=0 for one cycle while dm_req=1, then ack=1 → dm_req=0, state IDLE, ack ignored, stall=0.
